// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: owns HI/LO, runs mult/div as fixed-latency
// multi-cycle operations, and serves mthi/mtlo writes and mfhi/mflo reads.
module e_mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Req,
   input  logic [3:0]  E_MDop,
   input  logic [31:0] E_A,
   input  logic [31:0] E_B,
   output logic        E_start,
   output logic        E_busy,
   output logic [31:0] E_HILOout,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MFHI  = 4'd7;
   localparam logic [3:0] OP_MFLO  = 4'd8;

   // Signed divide via magnitudes so that 0x80000000 / -1 wraps cleanly to 0x80000000.
   // Returns {remainder, quotient}; caller must not pass b == 0.
   function automatic logic [63:0] div_signed(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] a_mag, b_mag, q_mag, r_mag, q, r;
      a_mag = a[31] ? (~a + 32'd1) : a;
      b_mag = b[31] ? (~b + 32'd1) : b;
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
      q     = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
      r     = a[31] ? (~r_mag + 32'd1) : r_mag;
      return {r, q};
   endfunction

   function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
      return {a % b, a / b};
   endfunction

   logic [31:0]      hi_q, hi_d, lo_q, lo_d;
   logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;

   logic signed [63:0] a_ext_s, b_ext_s, prod_s;
   logic        [63:0] prod_u;
   logic        [31:0] divisor;
   logic        [63:0] div_res_s, div_res_u;
   logic               is_md;

   assign a_ext_s   = {{32{E_A[31]}}, E_A};
   assign b_ext_s   = {{32{E_B[31]}}, E_B};
   assign prod_s    = a_ext_s * b_ext_s;
   assign prod_u    = {32'd0, E_A} * {32'd0, E_B};
   assign divisor   = (E_B == 32'd0) ? 32'd1 : E_B;
   assign div_res_s = div_signed(E_A, divisor);
   assign div_res_u = div_unsigned(E_A, divisor);

   assign is_md   = (E_MDop >= OP_MULT) && (E_MDop <= OP_DIVU);
   assign E_start = is_md & ~busy_q & ~Req & ~reset;

   always_comb begin
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      if (E_start) begin
         busy_d = 1'b1;
         unique case (E_MDop)
            OP_MULT: begin
               {pend_hi_d, pend_lo_d} = prod_s;
               cnt_d = MULT_LOAD;
            end
            OP_MULTU: begin
               {pend_hi_d, pend_lo_d} = prod_u;
               cnt_d = MULT_LOAD;
            end
            OP_DIV: begin
               // Divide by zero still occupies the unit, but commits HI/LO unchanged.
               {pend_hi_d, pend_lo_d} = (E_B == 32'd0) ? {hi_q, lo_q} : div_res_s;
               cnt_d = DIV_LOAD;
            end
            default: begin
               {pend_hi_d, pend_lo_d} = (E_B == 32'd0) ? {hi_q, lo_q} : div_res_u;
               cnt_d = DIV_LOAD;
            end
         endcase
      end else if (busy_q) begin
         cnt_d = cnt_q - CNT_ONE;
         if (cnt_q == CNT_ONE) begin
            hi_d   = pend_hi_q;
            lo_d   = pend_lo_q;
            busy_d = 1'b0;
         end
      end else if (!Req) begin
         if (E_MDop == OP_MTHI) hi_d = E_A;
         if (E_MDop == OP_MTLO) lo_d = E_A;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         pend_hi_q <= 32'd0;
         pend_lo_q <= 32'd0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
      end else begin
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
      end
   end

   assign E_busy    = busy_q;
   assign HI        = hi_q;
   assign LO        = lo_q;
   assign E_HILOout = (E_MDop == OP_MFHI) ? hi_q :
                      (E_MDop == OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: directed MD operations queue their expected HI/LO
// and busy length; a monitor checks them when busy drops.
module tb_e_mdu;

   logic        clk;
   logic        reset;
   logic        Req;
   logic [3:0]  E_MDop;
   logic [31:0] E_A;
   logic [31:0] E_B;
   logic        E_start;
   logic        E_busy;
   logic [31:0] E_HILOout;
   logic [31:0] HI;
   logic [31:0] LO;

   e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk       (clk),
      .reset     (reset),
      .Req       (Req),
      .E_MDop    (E_MDop),
      .E_A       (E_A),
      .E_B       (E_B),
      .E_start   (E_start),
      .E_busy    (E_busy),
      .E_HILOout (E_HILOout),
      .HI        (HI),
      .LO        (LO)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          len;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Inputs change 1 time unit after the edge; comb/registered outputs read 2 units later.
   task automatic cyc(input logic rst, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic rq);
      @(posedge clk);
      #1;
      reset  = rst;
      E_MDop = op;
      E_A    = a;
      E_B    = b;
      Req    = rq;
      #2;
   endtask

   task automatic push(input logic [31:0] hi, input logic [31:0] lo, input int len,
                       input string name);
      exp_t e;
      e.hi = hi; e.lo = lo; e.len = len; e.name = name;
      sb.push_back(e);
   endtask

   task automatic wait_idle(input string name);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
         if (!E_busy) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout: busy still high after 40 cycles, expected low", name);
      end
   endtask

   // Monitor: completion is the cycle where busy has just dropped.
   int busy_len  = 0;
   bit busy_prev = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (E_busy) begin
         busy_len++;
      end else if (busy_prev) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_completion: HI=%h LO=%h, expected no operation", HI, LO);
         end else begin
            e = sb.pop_front();
            chk({e.name, "_hi"}, HI, e.hi);
            chk({e.name, "_lo"}, LO, e.lo);
            chk({e.name, "_busy_len"}, busy_len, e.len);
         end
         busy_len = 0;
      end
      busy_prev = E_busy;
   end

   // A start must never be accepted while an operation is in flight.
   always @(negedge clk) begin
      assert (!(E_start && E_busy))
      else begin
         fails++;
         $display("FAIL start_while_busy: E_start=%b E_busy=%b, expected no start", E_start, E_busy);
      end
   end

   initial begin
      reset = 1'b1; Req = 1'b0; E_MDop = 4'd0; E_A = 32'd0; E_B = 32'd0;

      // Reset
      cyc(1'b1, 4'd1, 32'd5, 32'd6, 1'b0);
      chk("start_in_reset", {31'd0, E_start}, 32'd0);
      cyc(1'b1, 4'd0, 32'd0, 32'd0, 1'b0);
      cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
      chk("reset_hi", HI, 32'd0);
      chk("reset_lo", LO, 32'd0);
      chk("reset_busy", {31'd0, E_busy}, 32'd0);

      // mult signed -2 * 3
      cyc(1'b0, 4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
      chk("mult_start", {31'd0, E_start}, 32'd1);
      push(32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, "mult_neg");
      cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
      chk("mult_start_one_cycle", {31'd0, E_start}, 32'd0);
      chk("mult_busy", {31'd0, E_busy}, 32'd1);
      wait_idle("mult_neg");
      cyc(1'b0, 4'd8, 32'd0, 32'd0, 1'b0);
      chk("mflo_after_mult", E_HILOout, 32'hFFFF_FFFA);
      cyc(1'b0, 4'd7, 32'd0, 32'd0, 1'b0);
      chk("mfhi_after_mult", E_HILOout, 32'hFFFF_FFFF);
      cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
      chk("hilo_none_op", E_HILOout, 32'd0);

      // multu and divu
      cyc(1'b0, 4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
      push(32'd1, 32'hFFFF_FFFE, 5, "multu");
      wait_idle("multu");
      cyc(1'b0, 4'd4, 32'd7, 32'd2, 1'b0);
      push(32'd1, 32'd3, 10, "divu");
      wait_idle("divu");

      // Signed divide edge cases
      cyc(1'b0, 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
      push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, "div_neg");
      wait_idle("div_neg");
      cyc(1'b0, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      push(32'd0, 32'h8000_0000, 10, "div_ovf");
      wait_idle("div_ovf");

      // Preset HI/LO then divide by zero
      cyc(1'b0, 4'd5, 32'h11, 32'd0, 1'b0);
      cyc(1'b0, 4'd6, 32'h22, 32'd0, 1'b0);
      chk("mthi_preset", HI, 32'h11);
      cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
      chk("mtlo_preset", LO, 32'h22);
      cyc(1'b0, 4'd3, 32'd5, 32'd0, 1'b0);
      push(32'h11, 32'h22, 10, "div_zero");
      wait_idle("div_zero");

      // Req blocks a start
      cyc(1'b0, 4'd1, 32'd3, 32'd4, 1'b1);
      chk("req_blocks_start", {31'd0, E_start}, 32'd0);
      cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
      chk("req_busy_low", {31'd0, E_busy}, 32'd0);
      chk("req_hi_kept", HI, 32'h11);
      chk("req_lo_kept", LO, 32'h22);

      // Req during an in-flight mult does not abort it
      cyc(1'b0, 4'd1, 32'd3, 32'd4, 1'b0);
      push(32'd0, 32'd12, 5, "mult_req_mid");
      cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
      cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
      wait_idle("mult_req_mid");

      // mthi blocked by Req, then allowed
      cyc(1'b0, 4'd5, 32'hABCD, 32'd0, 1'b1);
      cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
      chk("mthi_req_blocked", HI, 32'd0);
      cyc(1'b0, 4'd5, 32'h1234, 32'd0, 1'b0);
      cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
      chk("mthi_write", HI, 32'h1234);

      // Busy blocks mtlo and restart; mfhi reads old HI
      cyc(1'b0, 4'd4, 32'd100, 32'd7, 1'b0);
      push(32'd2, 32'd14, 10, "divu_busy_block");
      cyc(1'b0, 4'd6, 32'hDEAD, 32'd0, 1'b0);
      cyc(1'b0, 4'd1, 32'd9, 32'd9, 1'b0);
      chk("mtlo_ignored_busy", LO, 32'd12);
      chk("start_ignored_busy", {31'd0, E_start}, 32'd0);
      cyc(1'b0, 4'd7, 32'd0, 32'd0, 1'b0);
      chk("mfhi_during_busy", E_HILOout, 32'h1234);
      wait_idle("divu_busy_block");

      // Reset mid-operation abandons the divide
      cyc(1'b0, 4'd4, 32'd50, 32'd3, 1'b0);
      push(32'd0, 32'd0, 4, "reset_mid_op");
      cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
      cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
      cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
      cyc(1'b1, 4'd0, 32'd0, 32'd0, 1'b0);
      cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
      chk("reset_mid_busy", {31'd0, E_busy}, 32'd0);
      for (int i = 0; i < 12; i++) cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
      chk("reset_mid_no_commit_hi", HI, 32'd0);
      chk("reset_mid_no_commit_lo", LO, 32'd0);

      chk("scoreboard_empty", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Execute-stage multiply/divide unit. Holds the architectural HI/LO registers.
- Runs mult/multu/div/divu as multi-cycle operations and performs mthi/mtlo writes.
- Drives the E-stage HILO read value (mfhi/mflo), which the EX/MEM pipeline register captures as E_HILOout.
- Exports busy/start so the hazard unit can stall dependent MD instructions in D.

Parameters:
- MULT_CYCLES, 5, cycles busy stays high after an accepted mult/multu (>=1).
- DIV_CYCLES, 10, cycles busy stays high after an accepted div/divu (>=1).

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high
- Req  input  1  exception/interrupt request this cycle; blocks new side effects
- E_MDop  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9-15 treated as none
- E_A  input  32  rs operand (forwarded)
- E_B  input  32  rt operand (forwarded)
- E_start  output  1  combinational; high when an op 1-4 is accepted this cycle
- E_busy  output  1  registered; high while an operation is in flight
- E_HILOout  output  32  combinational; HI if op=7, LO if op=8, else 0
- HI  output  32  architectural HI, registered
- LO  output  32  architectural LO, registered

Behaviour:
- Reset (sync, highest priority):
  - HI=0, LO=0, E_busy=0, internal counter=0, pending results=0.
  - E_start=0 whenever reset is high.
  - Reset mid-operation abandons the operation; HI/LO are not written.
- Acceptance rule: E_start = (op in 1..4) & ~E_busy & ~Req & ~reset.
  - Ops 1-4 presented while busy are ignored. The hazard unit guarantees this never happens; the bench checks for it with an assertion.
- On an accepted start:
  - Full results are latched into pending_hi/pending_lo.
  - Counter loads MULT_CYCLES or DIV_CYCLES.
  - E_busy=1 from the next cycle.
- Each busy cycle:
  - Counter decrements.
  - On the edge where the counter goes 1->0: HI<=pending_hi, LO<=pending_lo, E_busy<=0.
  - Latency: the start edge is edge 0. HI/LO are updated at edge N and readable in the first cycle with E_busy=0.
- Arithmetic:
  - mult: signed 32x32 -> 64; HI=upper, LO=lower.
  - multu: unsigned 32x32 -> 64.
  - div: signed; LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
    - 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
  - divu: unsigned.
  - Divide by zero (div or divu): the operation runs its full DIV_CYCLES, but pending = current HI/LO, so HI/LO are unchanged.
- mthi/mtlo:
  - Write E_A to HI/LO at the edge when op=5/6, ~E_busy, ~Req.
  - While busy they are ignored (stalled upstream).
  - Blocked by Req.
- mfhi/mflo: purely combinational read of the current HI/LO. No interaction with Req.
- Req semantics:
  - Req blocks the start and the mthi/mtlo side effects of the instruction in E that cycle.
  - Req does NOT abort an operation already in flight; it completes and commits HI/LO on schedule.
- Simultaneous events: reset > Req > accept. The completion edge and a new start cannot coincide because busy blocks the start.
- No combinational path from E_busy to E_start except via the registered busy.

Test Plan:
- mult signed: reset; op=1, A=0xFFFFFFFE (-2), B=3.
  - E_start=1 for 1 cycle; E_busy=1 for 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFA; op=8 gives E_HILOout=0xFFFFFFFA.
- multu/divu: op=2, A=0xFFFFFFFF, B=2 -> HI=1, LO=0xFFFFFFFE.
  - Then op=4, A=7, B=2 -> busy 10 cycles; HI=1, LO=3.
- Signed div edge cases:
  - A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
  - Preset HI=0x11, LO=0x22; A=5, B=0 -> busy 10 cycles, HI=0x11, LO=0x22.
- Req interaction:
  - op=1 with Req=1 -> E_start=0, busy stays 0, HI/LO unchanged.
  - Start mult 3x4, then Req=1 during cycle 2 of busy -> completes on schedule, LO=12.
  - op=5, A=0xABCD with Req=1 -> HI unchanged.
- mthi/mtlo and busy blocking:
  - op=5, A=0x1234 -> HI=0x1234 next cycle.
  - During a busy div: op=6 and op=1 are ignored (LO only gets the div result; no restart).
  - op=7 during busy returns the old HI.
- Reset mid-op: start div, assert reset at busy cycle 4 -> next cycle HI=LO=0, busy=0; the result is never committed.
